// File: rtl/spi_slave_rx.sv
// spi_slave_rx: SPI slave receiver/transmitter in the clk domain.
// The SPI pins are oversampled through synchronizers. spi_clk edges are
// recovered by comparing the synchronized level with a delayed copy. All
// four CPOL/CPHA modes are supported, and the mode is frozen for the
// duration of a frame. Bytes stream back-to-back while cs stays low.
module spi_slave_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       polarity,
  input  logic       phase,
  input  logic       spi_clk,
  input  logic       cs,
  input  logic       mosi,
  output logic       miso,
  input  logic [7:0] data_tx,
  output logic [7:0] data_rx,
  output logic       rx_valid,
  output logic       frame_err,
  output logic [1:0] state,
  output logic [3:0] bit_count
);

  localparam logic [1:0] IDLE        = 2'd0;
  localparam logic [1:0] ACTIVE      = 2'd1;
  // Cycles after reset release before the cs synchronizer shows the real pin.
  localparam logic [1:0] SETTLE_DONE = 2'(SYNC_STAGES);

  // Synchronizer chains; the top bit of each is the clk-domain copy.
  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   sclk_s;
  logic                   cs_s;
  logic                   mosi_s;
  logic                   sclk_d;

  // After reset, a frame may start only once cs has really been seen high.
  logic [1:0] settle_cnt;
  logic       armed;

  // Mode latched at frame start.
  logic pol_q;
  logic pha_q;

  // Shift registers.
  logic [7:0] rx_shift;
  logic [7:0] tx_shift;

  // Decoded events for the current clk cycle.
  logic       sclk_rise;
  logic       sclk_fall;
  logic       lead_edge;
  logic       trail_edge;
  logic       sample_edge;
  logic       shift_edge;
  logic       frame_start;
  logic       frame_stop;
  logic       do_sample;
  logic       do_shift;
  logic       byte_done;
  logic [7:0] rx_byte;

  // Move the asynchronous SPI pins into the clk domain.
  // NOTE: every register in this file uses non-blocking assignments. Each
  // flop then samples its input as it was before the clock edge, which is
  // what makes the chain shift by exactly one stage per clk.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_clk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
    end
  end

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  // Delay the synchronized spi_clk by one cycle for edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sclk_d <= 1'b0;
    end else begin
      sclk_d <= sclk_s;
    end
  end

  // Arm frame detection only after the cs chain has flushed its reset value
  // and cs is seen high. A cs held low across reset then cannot start a frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      settle_cnt <= 2'd0;
      armed      <= 1'b0;
    end else begin
      if (settle_cnt != SETTLE_DONE) begin
        settle_cnt <= settle_cnt + 2'd1;
      end else if (cs_s) begin
        armed <= 1'b1;
      end
    end
  end

  // Decode spi_clk edges into sample/shift events under the latched mode.
  // NOTE: every signal gets a value on every path through this block, so it
  // stays purely combinational and no latch is inferred.
  always_comb begin
    sclk_rise   = sclk_s & ~sclk_d;
    sclk_fall   = ~sclk_s & sclk_d;
    lead_edge   = pol_q ? sclk_fall : sclk_rise;
    trail_edge  = pol_q ? sclk_rise : sclk_fall;
    sample_edge = pha_q ? trail_edge : lead_edge;
    shift_edge  = pha_q ? lead_edge : trail_edge;
    // A rising cs takes priority over any edge seen in the same cycle.
    frame_start = (state == IDLE) && armed && !cs_s;
    frame_stop  = (state == ACTIVE) && cs_s;
    do_sample   = (state == ACTIVE) && !cs_s && sample_edge;
    do_shift    = (state == ACTIVE) && !cs_s && shift_edge;
    byte_done   = do_sample && (bit_count == 4'd7);
    rx_byte     = {rx_shift[6:0], mosi_s};
  end

  // Frame control: state, latched mode and bit counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      pol_q     <= 1'b0;
      pha_q     <= 1'b0;
      bit_count <= 4'd0;
    end else begin
      if (frame_start) begin
        state     <= ACTIVE;
        pol_q     <= polarity;
        pha_q     <= phase;
        bit_count <= 4'd0;
      end else if (frame_stop) begin
        state     <= IDLE;
        bit_count <= 4'd0;
      end else if (do_sample) begin
        bit_count <= byte_done ? 4'd0 : bit_count + 4'd1;
      end else if (state != IDLE && state != ACTIVE) begin
        state <= IDLE;
      end
    end
  end

  // Receive path: shift mosi in on sample edges and publish each full byte.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_shift <= 8'h00;
      data_rx  <= 8'h00;
      rx_valid <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      if (frame_start) begin
        rx_shift <= 8'h00;
      end else if (do_sample) begin
        rx_shift <= rx_byte;
        if (byte_done) begin
          data_rx  <= rx_byte;
          rx_valid <= 1'b1;
        end
      end
    end
  end

  // Transmit path. tx_shift[7] always holds the bit that the next shift edge
  // puts on miso. In CPHA=0 the MSB is already on the wire at frame start,
  // so the register is loaded pre-shifted. At a byte boundary it is reloaded
  // whole, because the following shift edge carries the new MSB.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_shift <= 8'h00;
      miso     <= 1'b1;
    end else begin
      if (frame_start) begin
        if (phase) begin
          tx_shift <= data_tx;
          miso     <= 1'b1;
        end else begin
          tx_shift <= {data_tx[6:0], 1'b0};
          miso     <= data_tx[7];
        end
      end else if (frame_stop) begin
        miso <= 1'b1;
      end else if (byte_done) begin
        tx_shift <= data_tx;
      end else if (do_shift) begin
        miso     <= tx_shift[7];
        tx_shift <= {tx_shift[6:0], 1'b0};
      end
    end
  end

  // Flag a frame that ends with a partially received byte.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_err <= 1'b0;
    end else begin
      frame_err <= frame_stop && (bit_count != 4'd0);
    end
  end

endmodule

// File: tb/tb_spi_slave_rx.sv
// tb_spi_slave_rx: acts as an SPI master, running all four modes under
// random data. The expected byte on data_rx is what the master shifted out.
// The expected byte on miso is the data_tx value in force for that byte.
module tb_spi_slave_rx;

  localparam int SYNC_STAGES = 2;
  localparam int HALF        = 4;  // spi_clk half period in clk cycles

  logic       clk = 1'b0;
  logic       reset;
  logic       polarity;
  logic       phase;
  logic       spi_clk;
  logic       cs;
  logic       mosi;
  logic       miso;
  logic [7:0] data_tx;
  logic [7:0] data_rx;
  logic       rx_valid;
  logic       frame_err;
  logic [1:0] state;
  logic [3:0] bit_count;

  int checks = 0;
  int errors = 0;

  // Master-side state.
  logic       mode_pol;
  logic       mode_pha;
  logic       toggle_pins;
  int         last_latency;
  logic [7:0] exp_data_rx;

  // Monitor results.
  logic [7:0] rx_q[$];
  int         rx_count   = 0;
  int         ferr_count = 0;
  int         pulse_viol = 0;
  logic       rx_valid_prev  = 1'b0;
  logic       frame_err_prev = 1'b0;

  spi_slave_rx #(.SYNC_STAGES(SYNC_STAGES)) dut (
    .clk       (clk),
    .reset     (reset),
    .polarity  (polarity),
    .phase     (phase),
    .spi_clk   (spi_clk),
    .cs        (cs),
    .mosi      (mosi),
    .miso      (miso),
    .data_tx   (data_tx),
    .data_rx   (data_rx),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .state     (state),
    .bit_count (bit_count)
  );

  always #5 clk = ~clk;

  // Record every received byte and frame error, and catch stretched pulses.
  always @(negedge clk) begin
    if (rx_valid) begin
      rx_q.push_back(data_rx);
      rx_count <= rx_count + 1;
    end
    if (frame_err) ferr_count <= ferr_count + 1;
    if ((rx_valid && rx_valid_prev) || (frame_err && frame_err_prev))
      pulse_viol <= pulse_viol + 1;
    rx_valid_prev  <= rx_valid;
    frame_err_prev <= frame_err;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Wait half an spi_clk period. When asked, record the delay to rx_valid.
  task automatic half_wait(input logic measure);
    for (int k = 1; k <= HALF; k++) begin
      @(negedge clk);
      if (measure && rx_valid && last_latency < 0) last_latency = k;
      if (toggle_pins) begin
        polarity = 1'($urandom);
        phase    = 1'($urandom);
      end
    end
  endtask

  task automatic frame_begin(input logic pol, input logic pha, input logic [7:0] tx0);
    cs       = 1'b1;
    mode_pol = pol;
    mode_pha = pha;
    polarity = pol;
    phase    = pha;
    spi_clk  = pol;
    mosi     = 1'b1;
    data_tx  = tx0;
    repeat (8) @(negedge clk);
    cs = 1'b0;
    half_wait(1'b0);
  endtask

  task automatic frame_end();
    half_wait(1'b0);
    cs = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  // Send nbits of tx MSB first, and capture miso as the master would.
  task automatic spi_bits(input logic [7:0] tx, input int nbits,
                          input logic [7:0] next_tx, output logic [7:0] got);
    got = 8'h00;
    for (int i = 7; i > 7 - nbits; i--) begin
      if (!mode_pha) begin
        mosi = tx[i];
        half_wait(1'b0);
        got[i]  = miso;
        spi_clk = ~mode_pol;
        last_latency = -1;
        half_wait(i == 0);
        spi_clk = mode_pol;
      end else begin
        spi_clk = ~mode_pol;
        mosi    = tx[i];
        half_wait(1'b0);
        got[i]  = miso;
        spi_clk = mode_pol;
        last_latency = -1;
        half_wait(i == 0);
      end
      if (i == 7) data_tx = next_tx;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state); end
    checks++; if (bit_count !== 4'd0) begin errors++; $display("FAIL reset_bit_count: got %0d expected 0", bit_count); end
    checks++; if (data_rx !== 8'h00) begin errors++; $display("FAIL reset_data_rx: got %h expected 00", data_rx); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid: got %b expected 0", rx_valid); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
    checks++; if (miso !== 1'b1) begin errors++; $display("FAIL reset_miso: got %b expected 1", miso); end
    reset = 1'b1;
    repeat (6) @(negedge clk);
    exp_data_rx = 8'h00;
  endtask

  task automatic test_mode0();
    logic [7:0] got;
    int rb = rx_count;
    int fb = ferr_count;
    frame_begin(1'b0, 1'b0, 8'h3C);
    checks++; if (miso !== 1'b0) begin errors++; $display("FAIL mode0_first_miso: got %b expected 0", miso); end
    spi_bits(8'hA5, 8, 8'h3C, got);
    frame_end();
    exp_data_rx = 8'hA5;
    checks++; if (got !== 8'h3C) begin errors++; $display("FAIL mode0_miso: got %h expected 3c", got); end
    checks++; if (rx_count - rb !== 1) begin errors++; $display("FAIL mode0_rx_pulses: got %0d expected 1", rx_count - rb); end
    checks++; if (data_rx !== exp_data_rx) begin errors++; $display("FAIL mode0_data_rx: got %h expected %h", data_rx, exp_data_rx); end
    checks++; if (ferr_count - fb !== 0) begin errors++; $display("FAIL mode0_frame_err: got %0d expected 0", ferr_count - fb); end
    checks++; if (last_latency !== SYNC_STAGES + 1) begin errors++; $display("FAIL mode0_latency: got %0d expected %0d", last_latency, SYNC_STAGES + 1); end
  endtask

  task automatic test_modes();
    for (int m = 1; m <= 3; m++) begin
      logic [7:0] got;
      logic pol = 1'(m >> 1);
      logic pha = 1'(m & 1);
      int rb = rx_count;
      frame_begin(pol, pha, 8'h3C);
      checks++; if (miso !== (pha ? 1'b1 : 1'b0)) begin errors++; $display("FAIL mode%0d_first_miso: got %b expected %b", m, miso, pha ? 1'b1 : 1'b0); end
      spi_bits(8'hA5, 8, 8'h3C, got);
      frame_end();
      exp_data_rx = 8'hA5;
      checks++; if (got !== 8'h3C) begin errors++; $display("FAIL mode%0d_miso: got %h expected 3c", m, got); end
      checks++; if (rx_count - rb !== 1) begin errors++; $display("FAIL mode%0d_rx_pulses: got %0d expected 1", m, rx_count - rb); end
      checks++; if (data_rx !== exp_data_rx) begin errors++; $display("FAIL mode%0d_data_rx: got %h expected a5", m, data_rx); end
      checks++; if (last_latency !== SYNC_STAGES + 1) begin errors++; $display("FAIL mode%0d_latency: got %0d expected %0d", m, last_latency, SYNC_STAGES + 1); end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] rxb[3] = '{8'h01, 8'hFF, 8'h80};
    logic [7:0] txb[4];
    logic [7:0] got;
    logic [1:0] m = 2'($urandom_range(0, 3));
    int rb = rx_count;
    for (int k = 0; k < 4; k++) txb[k] = 8'($urandom);
    frame_begin(m[1], m[0], txb[0]);
    for (int k = 0; k < 3; k++) begin
      spi_bits(rxb[k], 8, txb[k+1], got);
      checks++; if (got !== txb[k]) begin errors++; $display("FAIL b2b_miso_%0d: got %h expected %h", k, got, txb[k]); end
      checks++; if (state !== 2'd1) begin errors++; $display("FAIL b2b_state_%0d: got %0d expected 1", k, state); end
    end
    frame_end();
    exp_data_rx = 8'h80;
    checks++; if (rx_count - rb !== 3) begin errors++; $display("FAIL b2b_rx_pulses: got %0d expected 3", rx_count - rb); end
    for (int k = 0; k < 3; k++) begin
      logic [7:0] seen = (rb + k < rx_q.size()) ? rx_q[rb + k] : 8'hxx;
      checks++; if (seen !== rxb[k]) begin errors++; $display("FAIL b2b_byte_%0d: got %h expected %h", k, seen, rxb[k]); end
    end
  endtask

  task automatic test_abort();
    logic [7:0] got;
    logic [1:0] m = 2'($urandom_range(0, 3));
    int rb = rx_count;
    int fb = ferr_count;
    frame_begin(m[1], m[0], 8'($urandom));
    spi_bits(8'h5A, 5, 8'($urandom), got);
    frame_end();
    checks++; if (ferr_count - fb !== 1) begin errors++; $display("FAIL abort_frame_err: got %0d expected 1", ferr_count - fb); end
    checks++; if (rx_count - rb !== 0) begin errors++; $display("FAIL abort_rx_pulses: got %0d expected 0", rx_count - rb); end
    checks++; if (data_rx !== exp_data_rx) begin errors++; $display("FAIL abort_data_rx: got %h expected %h", data_rx, exp_data_rx); end
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL abort_state: got %0d expected 0", state); end
    checks++; if (miso !== 1'b1) begin errors++; $display("FAIL abort_miso: got %b expected 1", miso); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] got;
    logic [7:0] tx = 8'($urandom);
    logic [1:0] m = 2'($urandom_range(0, 3));
    int rb, fb;
    frame_begin(m[1], m[0], 8'($urandom));
    spi_bits(8'($urandom), 3, 8'($urandom), got);
    repeat (2) @(negedge clk);
    rb = rx_count;
    fb = ferr_count;
    reset = 1'b0;
    @(negedge clk);
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL rstmid_state: got %0d expected 0", state); end
    checks++; if (bit_count !== 4'd0) begin errors++; $display("FAIL rstmid_bit_count: got %0d expected 0", bit_count); end
    checks++; if (data_rx !== 8'h00) begin errors++; $display("FAIL rstmid_data_rx: got %h expected 00", data_rx); end
    checks++; if (miso !== 1'b1) begin errors++; $display("FAIL rstmid_miso: got %b expected 1", miso); end
    checks++; if (rx_valid !== 1'b0 || frame_err !== 1'b0) begin errors++; $display("FAIL rstmid_pulses: got %b%b expected 00", rx_valid, frame_err); end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    exp_data_rx = 8'h00;
    // cs is still low: clocks now must not start a frame.
    repeat (10) @(negedge clk);
    for (int e = 0; e < 4; e++) begin
      spi_clk = ~spi_clk;
      half_wait(1'b0);
    end
    checks++; if (state !== 2'd0 || bit_count !== 4'd0) begin errors++; $display("FAIL rstmid_no_restart: got state %0d count %0d expected 0 0", state, bit_count); end
    frame_begin(m[1], m[0], tx);
    spi_bits(8'hC3, 8, tx, got);
    frame_end();
    exp_data_rx = 8'hC3;
    checks++; if (data_rx !== exp_data_rx) begin errors++; $display("FAIL rstmid_data_rx_after: got %h expected c3", data_rx); end
    checks++; if (got !== tx) begin errors++; $display("FAIL rstmid_miso_after: got %h expected %h", got, tx); end
    checks++; if (rx_count - rb !== 1) begin errors++; $display("FAIL rstmid_rx_pulses: got %0d expected 1", rx_count - rb); end
    checks++; if (ferr_count - fb !== 0) begin errors++; $display("FAIL rstmid_frame_err: got %0d expected 0", ferr_count - fb); end
  endtask

  task automatic test_mode_toggle();
    for (int m = 0; m < 4; m++) begin
      logic [7:0] got;
      logic [7:0] b  = 8'($urandom);
      logic [7:0] tx = 8'($urandom);
      frame_begin(1'(m >> 1), 1'(m & 1), tx);
      toggle_pins = 1'b1;
      spi_bits(b, 8, tx, got);
      toggle_pins = 1'b0;
      frame_end();
      exp_data_rx = b;
      checks++; if (data_rx !== exp_data_rx) begin errors++; $display("FAIL toggle%0d_data_rx: got %h expected %h", m, data_rx, exp_data_rx); end
      checks++; if (got !== tx) begin errors++; $display("FAIL toggle%0d_miso: got %h expected %h", m, got, tx); end
    end
  endtask

  task automatic test_random();
    for (int f = 0; f < 12; f++) begin
      logic [7:0] rxb[3];
      logic [7:0] txb[4];
      logic [7:0] got;
      logic [1:0] m  = 2'($urandom_range(0, 3));
      int         nb = $urandom_range(1, 3);
      int         rb = rx_count;
      for (int k = 0; k < 4; k++) txb[k] = 8'($urandom);
      for (int k = 0; k < 3; k++) rxb[k] = 8'($urandom);
      frame_begin(m[1], m[0], txb[0]);
      for (int k = 0; k < nb; k++) begin
        spi_bits(rxb[k], 8, txb[k+1], got);
        checks++; if (got !== txb[k]) begin errors++; $display("FAIL rand%0d_miso_%0d: got %h expected %h", f, k, got, txb[k]); end
        checks++; if (last_latency !== SYNC_STAGES + 1) begin errors++; $display("FAIL rand%0d_latency_%0d: got %0d expected %0d", f, k, last_latency, SYNC_STAGES + 1); end
      end
      frame_end();
      exp_data_rx = rxb[nb-1];
      checks++; if (rx_count - rb !== nb) begin errors++; $display("FAIL rand%0d_rx_pulses: got %0d expected %0d", f, rx_count - rb, nb); end
      for (int k = 0; k < nb; k++) begin
        logic [7:0] seen = (rb + k < rx_q.size()) ? rx_q[rb + k] : 8'hxx;
        checks++; if (seen !== rxb[k]) begin errors++; $display("FAIL rand%0d_byte_%0d: got %h expected %h", f, k, seen, rxb[k]); end
      end
      checks++; if (data_rx !== exp_data_rx) begin errors++; $display("FAIL rand%0d_data_rx: got %h expected %h", f, data_rx, exp_data_rx); end
    end
  endtask

  task automatic test_pulses();
    checks++; if (pulse_viol !== 0) begin errors++; $display("FAIL pulse_width: got %0d stretched pulses expected 0", pulse_viol); end
  endtask

  initial begin
    reset       = 1'b0;
    cs          = 1'b1;
    spi_clk     = 1'b0;
    mosi        = 1'b1;
    polarity    = 1'b0;
    phase       = 1'b0;
    data_tx     = 8'h00;
    toggle_pins = 1'b0;
    mode_pol    = 1'b0;
    mode_pha    = 1'b0;
    last_latency = -1;
    exp_data_rx = 8'h00;
    test_reset();
    test_mode0();
    test_modes();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    test_mode_toggle();
    test_random();
    test_pulses();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_slave_rx.md
SPI_SLAVE_RX -- requirements
Module: spi_slave_rx

Interface
REQ-001 Parameter SYNC_STAGES, default 2: number of flip-flops in each input synchronizer; legal values 2..3.
REQ-002 Port clk, input, 1: system clock; every register in the block is clocked on its rising edge.
REQ-003 Port reset, input, 1: reset, asynchronous and active-low.
REQ-004 Port polarity, input, 1: SPI clock polarity (CPOL); spi_clk idles at this level.
REQ-005 Port phase, input, 1: SPI clock phase (CPHA).
REQ-006 Port spi_clk, input, 1: serial clock from the SPI master; asynchronous to clk.
REQ-007 Port cs, input, 1: chip select from the master, active-low.
REQ-008 Port mosi, input, 1: serial data from the master, MSB first.
REQ-009 Port miso, output, 1: serial data to the master, MSB first; idles at 1 (pull-up level).
REQ-010 Port data_tx, input, 8: byte to return on miso; sampled at frame start and at each byte boundary.
REQ-011 Port data_rx, output, 8: last completely received byte.
REQ-012 Port rx_valid, output, 1: one-clk pulse marking a new byte on data_rx.
REQ-013 Port frame_err, output, 1: one-clk pulse when cs deasserts mid-byte.
REQ-014 Port state, output, 2: current FSM state (0 IDLE, 1 ACTIVE).
REQ-015 Port bit_count, output, 4: bits received in the current byte, range 0..7.

Function
REQ-016 spi_clk, cs and mosi SHALL each pass through a SYNC_STAGES-deep synchronizer clocked by clk (cs and mosi reset to 1, spi_clk resets to 0); all logic uses only the synchronized copies.
REQ-017 spi_clk edges SHALL be detected by comparing the synchronized value with a one-cycle-delayed copy.
REQ-018 polarity and phase SHALL be latched on entry to ACTIVE and held until return to IDLE; changes while ACTIVE SHALL be ignored.
REQ-019 Leading edge SHALL be rising when latched polarity=0 and falling when latched polarity=1.
REQ-020 Sample edge SHALL be the leading edge when latched phase=0 and the trailing edge when latched phase=1; the shift edge is the opposite edge.
REQ-021 IDLE -> ACTIVE SHALL occur on the clk cycle where synchronized cs is first seen low: load tx_shift with data_tx, clear bit_count, and drive miso=data_tx[7] when phase=0.
REQ-022 In ACTIVE, each sample edge SHALL shift synchronized mosi into the LSB of rx_shift and increment bit_count.
REQ-023 In ACTIVE, each shift edge SHALL advance tx_shift and drive the next bit on miso; when phase=1, the first shift edge drives bit 7.
REQ-024 On the 8th sample edge, in the same clk cycle, the block SHALL load data_rx with the complete byte (earlier 7 bits plus the current mosi) and pulse rx_valid, wrap bit_count to 0, and reload tx_shift from data_tx.
REQ-025 While cs stays low, bytes SHALL be received back-to-back without gaps and without returning to IDLE.
REQ-026 ACTIVE -> IDLE SHALL occur when synchronized cs is seen high. If bit_count != 0, the block pulses frame_err for one clk, discards the partial byte, and leaves data_rx unchanged. miso returns to 1.
REQ-027 If cs deasserts on the same clk cycle as a sample edge, the cs deassertion SHALL take priority and that edge SHALL be ignored.
REQ-028 spi_clk edges seen in IDLE SHALL be ignored.
REQ-029 Latency from a raw spi_clk edge to its effect (rx_valid, miso update) SHALL be SYNC_STAGES+1 clk cycles.
REQ-030 Correct operation SHALL require spi_clk high and low times each of at least SYNC_STAGES+1 clk periods, and cs setup/hold of at least one spi_clk half-period.
REQ-031 rx_valid and frame_err SHALL never be high for more than one consecutive clk; data_rx SHALL hold its value until the next rx_valid.

Reset
REQ-032 Asserting reset (low) SHALL immediately set: state=IDLE, bit_count=0, data_rx=0, rx_valid=0, frame_err=0, miso=1, shift registers=0, latched mode=0.
REQ-033 Reset asserted mid-frame SHALL abandon the frame without a frame_err pulse; after release, the block waits in IDLE for a fresh cs high-to-low transition.

Verification
REQ-034 Mode 0: clk:spi_clk ratio 8; cs low; master sends 0xA5 with data_tx=0x3C -> single rx_valid pulse with data_rx=0xA5; miso bits 0,0,1,1,1,1,0,0 on successive sample edges.
REQ-035 Modes 1, 2 and 3: same byte 0xA5 -> data_rx=0xA5 each time; when phase=1, miso bit 7 appears only after the first shift edge.
REQ-036 Back-to-back: cs held low over bytes 0x01, 0xFF, 0x80 -> three rx_valid pulses with data_rx = 0x01, 0xFF, 0x80 in order; state stays 1 throughout.
REQ-037 Abort: cs raised after 5 bits of 0x5A -> frame_err pulses once, no rx_valid, data_rx keeps its previous value, state=0, miso=1.
REQ-038 Reset mid-byte after 3 bits, then a full frame of 0xC3 -> outputs match REQ-032 during reset; after release, data_rx=0xC3 with no frame_err.
REQ-039 Mode pins toggled during an active frame -> received byte unaffected.
